// File: rtl/direction_validator_if.sv
// Board memory port between the direction walker (master) and the board RAM (slave).
interface direction_validator_if;
    logic [6:0] mem_addr_o;
    logic [1:0] mem_data_i;
    logic       mem_we_o;
    logic [1:0] mem_wdata_o;

    modport master (
        output mem_addr_o,
        output mem_we_o,
        output mem_wdata_o,
        input  mem_data_i
    );

    modport slave (
        input  mem_addr_o,
        input  mem_we_o,
        input  mem_wdata_o,
        output mem_data_i
    );
endinterface

// File: rtl/direction_validator.sv
// Walks one direction from a candidate move and reports whether it brackets opponent pieces.
// Optional run flipping on success is built only when VALI_FLIP_EN is defined.
module direction_validator #(
    parameter int BOARD_CELLS = 100,
    parameter int MAX_RUN     = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ld,
    input  logic                 enable,
    input  logic [4:0]           step_in,
    input  logic [6:0]           e_addr_in,
    input  logic [1:0]           player_in,
    input  logic                 flip_in,
    direction_validator_if.master mem,
    output logic                 s_done_o,
    output logic                 dir_status_o
);

`ifdef VALI_FLIP_EN
    localparam bit FLIP_BUILT = 1'b1;
`else
    localparam bit FLIP_BUILT = 1'b0;
`endif
    localparam int NW = $clog2(MAX_RUN + 1);

    typedef enum logic [2:0] {IDLE, RD, CHK, FLIP, DONE} state_t;
    state_t state, state_nxt;

    logic [4:0]        step_r;
    logic [6:0]        origin_r;
    logic [1:0]        player_r;
    logic              flip_r;
    logic [NW-1:0]     n;
    logic signed [8:0] cur;

    logic [4:0]        step_eff;
    logic [6:0]        origin_eff;
    logic signed [8:0] step_x, start_cur, next_cur, back_cur;
    logic [1:0]        opponent;
    logic              run_full, hit_opp, hit_own;

    function automatic logic in_range(input logic signed [8:0] a);
        return (int'(a) >= 0) && (int'(a) < BOARD_CELLS);
    endfunction

    // A start in the same cycle as ld walks from the freshly presented values.
    always_comb begin
        step_eff   = ld ? step_in : step_r;
        origin_eff = ld ? e_addr_in : origin_r;
        start_cur  = $signed({2'b00, origin_eff}) + $signed({{4{step_eff[4]}}, step_eff});
        step_x     = $signed({{4{step_r[4]}}, step_r});
        next_cur   = cur + step_x;
        back_cur   = cur - step_x;
        opponent   = {player_r[0], player_r[1]};
        run_full   = (int'(n) + 1 >= MAX_RUN);
        hit_opp    = (mem.mem_data_i == opponent);
        hit_own    = (mem.mem_data_i == player_r);
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (enable)              state_nxt = in_range(start_cur) ? RD : DONE;
                else if (state == DONE)  state_nxt = IDLE;
            end
            RD:  state_nxt = CHK;
            CHK: begin
                if (hit_opp)
                    state_nxt = (run_full || !in_range(next_cur)) ? DONE : RD;
                else if (hit_own && (n != '0) && flip_r && FLIP_BUILT)
                    state_nxt = FLIP;
                else
                    state_nxt = DONE;
            end
            FLIP: if (n == NW'(1)) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // On success cur steps back onto the last opponent cell so FLIP can retrace the run.
    always_ff @(posedge clock) begin
        if (!reset) begin
            step_r       <= '0;
            origin_r     <= '0;
            player_r     <= '0;
            flip_r       <= 1'b0;
            n            <= '0;
            cur          <= '0;
            dir_status_o <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (ld) begin
                        step_r   <= step_in;
                        origin_r <= e_addr_in;
                        player_r <= player_in;
                        flip_r   <= flip_in;
                    end
                    if (enable) begin
                        n            <= '0;
                        dir_status_o <= 1'b0;
                        cur          <= start_cur;
                    end
                end
                CHK: begin
                    if (hit_opp) begin
                        n   <= n + 1'b1;
                        cur <= next_cur;
                    end else if (hit_own) begin
                        dir_status_o <= (n != '0);
                        cur          <= back_cur;
                    end
                end
                FLIP: begin
                    n   <= n - 1'b1;
                    cur <= back_cur;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_done_o        = (state == DONE);
        mem.mem_addr_o  = '0;
        mem.mem_we_o    = 1'b0;
        mem.mem_wdata_o = '0;
        if (state == RD || state == FLIP) mem.mem_addr_o = cur[6:0];
`ifdef VALI_FLIP_EN
        if (state == FLIP) begin
            mem.mem_we_o    = 1'b1;
            mem.mem_wdata_o = player_r;
        end
`endif
    end

endmodule

// File: tb/tb_direction_validator.sv
// Randomised and directed checks of direction_validator against a board-walk reference model.
module tb_direction_validator;
    localparam int  MAXR = 8;
`ifdef VALI_FLIP_EN
    localparam bit FLIP_ON = 1'b1;
`else
    localparam bit FLIP_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ld = 1'b0, enable = 1'b0, flip_in = 1'b0;
    logic [4:0] step_in = '0;
    logic [6:0] e_addr_in = '0;
    logic [1:0] player_in = '0;
    logic       s_done_o, dir_status_o;

    direction_validator_if bus();

    direction_validator #(.BOARD_CELLS(100), .MAX_RUN(MAXR)) dut (
        .clock(clock), .reset(reset), .ld(ld), .enable(enable),
        .step_in(step_in), .e_addr_in(e_addr_in), .player_in(player_in), .flip_in(flip_in),
        .mem(bus), .s_done_o(s_done_o), .dir_status_o(dir_status_o)
    );

    always #5 clock = ~clock;

    logic [1:0] board  [0:127];
    logic [1:0] shadow [0:127];
    logic       load_req = 1'b0;

    always @(posedge clock) begin
        if (load_req)          board <= shadow;
        else if (bus.mem_we_o) board[bus.mem_addr_o] <= bus.mem_wdata_o;
        bus.mem_data_i <= board[bus.mem_addr_o];
    end

    int passed = 0, total = 0;
    int wr_addr_q[$];
    int wr_cyc_q[$];
    logic [1:0] wr_data_q[$];
    int steps [8] = '{-11, -10, -9, -1, 1, 9, 10, 11};

    task automatic blank_shadow();
        for (int a = 0; a < 128; a++) begin
            if (a < 100 && (a / 10 == 0 || a / 10 == 9 || a % 10 == 0 || a % 10 == 9))
                shadow[a] = 2'b11;
            else
                shadow[a] = 2'b00;
        end
    endtask

    task automatic load_board();
        @(negedge clock);
        load_req = 1'b1;
        @(posedge clock); #1;
        load_req = 1'b0;
    endtask

    task automatic capture_board();
        blank_shadow();
        shadow[35] = 2'b10; shadow[36] = 2'b10; shadow[37] = 2'b01;
        load_board();
    endtask

    // Leaves the caller at cycle 1 (1 time unit after the sampled enable edge).
    task automatic start_walk(input int origin, input int step, input logic [1:0] pl,
                              input logic fl, input logic with_ld);
        @(negedge clock);
        ld = with_ld; enable = 1'b1;
        e_addr_in = 7'(origin); step_in = 5'(step); player_in = pl; flip_in = fl;
        @(posedge clock); #1;
        ld = 1'b0; enable = 1'b0;
    endtask

    task automatic measure(input int c0, output int lat, output logic st);
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        lat = -1; st = 1'b0;
        for (int c = c0; c <= 60; c++) begin
            if (bus.mem_we_o) begin
                wr_addr_q.push_back(int'(bus.mem_addr_o));
                wr_data_q.push_back(bus.mem_wdata_o);
                wr_cyc_q.push_back(c);
            end
            if (s_done_o) begin
                lat = c; st = dir_status_o;
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    // Reference: follow the line cell by cell over the current board contents.
    task automatic model_walk(input int origin, input int step, input logic [1:0] pl,
                              input logic fl, output int lat, output logic st, output int nrun);
        int cur = origin + step;
        int m = 0;
        int n = 0;
        logic [1:0] opp = (pl == 2'b01) ? 2'b10 : 2'b01;
        st = 1'b0;
        while (cur >= 0 && cur < 100) begin
            m++;
            if (board[cur] == opp) begin
                n++;
                if (n == MAXR) break;
                cur += step;
            end else begin
                st = (board[cur] == pl) && (n >= 1);
                break;
            end
        end
        lat  = 2 * m + 1 + ((FLIP_ON && fl && st) ? n : 0);
        nrun = n;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        total++; if (s_done_o !== 1'b0) $display("FAIL reset_done got %b want 0", s_done_o); else passed++;
        total++; if (dir_status_o !== 1'b0) $display("FAIL reset_status got %b want 0", dir_status_o); else passed++;
        total++; if (bus.mem_we_o !== 1'b0) $display("FAIL reset_we got %b want 0", bus.mem_we_o); else passed++;
        total++; if (bus.mem_addr_o !== 7'd0) $display("FAIL reset_addr got %0d want 0", bus.mem_addr_o); else passed++;
        total++; if (bus.mem_wdata_o !== 2'b00) $display("FAIL reset_wdata got %b want 00", bus.mem_wdata_o); else passed++;
        reset = 1'b1;
    endtask

    task automatic test_capture();
        int lat; logic st;
        capture_board();
        start_walk(34, 1, 2'b01, 1'b0, 1'b1);
        measure(1, lat, st);
        total++; if (lat !== 7) $display("FAIL capture_latency got %0d want 7", lat); else passed++;
        total++; if (st !== 1'b1) $display("FAIL capture_status got %b want 1", st); else passed++;
        total++; if (wr_addr_q.size() != 0) $display("FAIL capture_writes got %0d want 0", wr_addr_q.size()); else passed++;
        @(posedge clock); #1;
        total++; if (s_done_o !== 1'b0) $display("FAIL capture_pulse_width got %b want 0", s_done_o); else passed++;
        @(posedge clock); #1;
        total++; if (dir_status_o !== 1'b1) $display("FAIL capture_status_hold got %b want 1", dir_status_o); else passed++;
    endtask

    task automatic test_flip();
        int lat; logic st;
        capture_board();
        start_walk(34, 1, 2'b01, 1'b1, 1'b1);
        measure(1, lat, st);
        total++; if (st !== 1'b1) $display("FAIL flip_status got %b want 1", st); else passed++;
`ifdef VALI_FLIP_EN
        total++; if (lat !== 9) $display("FAIL flip_latency got %0d want 9", lat); else passed++;
        total++;
        if (wr_addr_q.size() != 2) $display("FAIL flip_write_count got %0d want 2", wr_addr_q.size());
        else begin
            passed++;
            total++; if (wr_addr_q[0] != 36 || wr_addr_q[1] != 35)
                $display("FAIL flip_write_addr got %0d,%0d want 36,35", wr_addr_q[0], wr_addr_q[1]); else passed++;
            total++; if (wr_data_q[0] !== 2'b01 || wr_data_q[1] !== 2'b01)
                $display("FAIL flip_write_data got %b,%b want 01,01", wr_data_q[0], wr_data_q[1]); else passed++;
            total++; if (wr_cyc_q[1] != wr_cyc_q[0] + 1)
                $display("FAIL flip_write_cycles got %0d,%0d want consecutive", wr_cyc_q[0], wr_cyc_q[1]); else passed++;
        end
        total++; if (board[35] !== 2'b01 || board[36] !== 2'b01)
            $display("FAIL flip_board got %b,%b want 01,01", board[35], board[36]); else passed++;
`else
        total++; if (lat !== 7) $display("FAIL noflip_latency got %0d want 7", lat); else passed++;
        total++; if (wr_addr_q.size() != 0) $display("FAIL noflip_writes got %0d want 0", wr_addr_q.size()); else passed++;
`endif
    endtask

    task automatic test_blocked();
        int lat; logic st;
        blank_shadow(); shadow[35] = 2'b01; load_board();
        start_walk(34, 1, 2'b01, 1'b0, 1'b1);
        measure(1, lat, st);
        total++; if (lat !== 3) $display("FAIL blocked_latency got %0d want 3", lat); else passed++;
        total++; if (st !== 1'b0) $display("FAIL blocked_status got %b want 0", st); else passed++;
    endtask

    task automatic test_range();
        int lat; logic st;
        blank_shadow(); shadow[5] = 2'b10; load_board();
        start_walk(11, -10, 2'b01, 1'b0, 1'b1);
        measure(1, lat, st);
        total++; if (lat !== 3 || st !== 1'b0) $display("FAIL border_walk got lat=%0d st=%b want lat=3 st=0", lat, st); else passed++;
        start_walk(5, -10, 2'b01, 1'b0, 1'b1);
        measure(1, lat, st);
        total++; if (lat !== 1 || st !== 1'b0) $display("FAIL oor_start got lat=%0d st=%b want lat=1 st=0", lat, st); else passed++;
        total++; if (bus.mem_addr_o !== 7'd0) $display("FAIL oor_no_read got addr=%0d want 0", bus.mem_addr_o); else passed++;
        start_walk(99, 1, 2'b10, 1'b0, 1'b1);
        measure(1, lat, st);
        total++; if (lat !== 1 || st !== 1'b0) $display("FAIL oor_top got lat=%0d st=%b want lat=1 st=0", lat, st); else passed++;
        start_walk(15, -10, 2'b01, 1'b0, 1'b1);
        measure(1, lat, st);
        total++; if (lat !== 3 || st !== 1'b0) $display("FAIL oor_mid_run got lat=%0d st=%b want lat=3 st=0", lat, st); else passed++;
    endtask

    task automatic test_max_run();
        int lat; logic st;
        blank_shadow();
        for (int a = 41; a <= 48; a++) shadow[a] = 2'b10;
        shadow[49] = 2'b01;
        load_board();
        start_walk(40, 1, 2'b01, 1'b0, 1'b1);
        measure(1, lat, st);
        total++; if (lat !== 17 || st !== 1'b0) $display("FAIL max_run_abort got lat=%0d st=%b want lat=17 st=0", lat, st); else passed++;
        start_walk(41, 1, 2'b01, 1'b0, 1'b1);
        measure(1, lat, st);
        total++; if (lat !== 17 || st !== 1'b1) $display("FAIL max_run_minus1 got lat=%0d st=%b want lat=17 st=1", lat, st); else passed++;
    endtask

    task automatic test_reset_midwalk();
        int lat; logic st; int pulses = 0; int writes = 0;
        capture_board();
        start_walk(34, 1, 2'b01, 1'b1, 1'b1);
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b0;
        @(posedge clock); #1;
        total++; if (s_done_o !== 1'b0 || dir_status_o !== 1'b0 || bus.mem_we_o !== 1'b0 ||
                     bus.mem_addr_o !== 7'd0 || bus.mem_wdata_o !== 2'b00)
            $display("FAIL midwalk_reset_outputs got done=%b st=%b we=%b addr=%0d wd=%b want all 0",
                     s_done_o, dir_status_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o); else passed++;
        reset = 1'b1;
        repeat (12) begin
            @(posedge clock); #1;
            if (s_done_o) pulses++;
            if (bus.mem_we_o) writes++;
        end
        total++; if (pulses != 0 || writes != 0)
            $display("FAIL midwalk_abort got pulses=%0d writes=%0d want 0,0", pulses, writes); else passed++;
        start_walk(34, 1, 2'b01, 1'b0, 1'b1);
        measure(1, lat, st);
        total++; if (lat !== 7 || st !== 1'b1) $display("FAIL midwalk_restart got lat=%0d st=%b want lat=7 st=1", lat, st); else passed++;
    endtask

    task automatic test_enable_ignored();
        int lat; logic st; int pulses = 0;
        capture_board();
        start_walk(34, 1, 2'b01, 1'b0, 1'b1);
        @(posedge clock); #1;
        ld = 1'b1; enable = 1'b1; e_addr_in = 7'd11; step_in = 5'(-10); player_in = 2'b10;
        @(posedge clock); #1;
        ld = 1'b0; enable = 1'b0;
        measure(3, lat, st);
        total++; if (lat !== 7 || st !== 1'b1) $display("FAIL ignored_enable got lat=%0d st=%b want lat=7 st=1", lat, st); else passed++;
        repeat (8) begin @(posedge clock); #1; if (s_done_o) pulses++; end
        total++; if (pulses != 0) $display("FAIL single_pulse got extra=%0d want 0", pulses); else passed++;
        start_walk(0, 0, 2'b00, 1'b0, 1'b0);
        measure(1, lat, st);
        total++; if (lat !== 7 || st !== 1'b1) $display("FAIL ld_ignored_midwalk got lat=%0d st=%b want lat=7 st=1", lat, st); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat; logic st;
        capture_board();
        start_walk(34, 1, 2'b01, 1'b0, 1'b1);
        measure(1, lat, st);
        ld = 1'b1; enable = 1'b1; e_addr_in = 7'd38; step_in = 5'(-1); player_in = 2'b10; flip_in = 1'b0;
        @(posedge clock); #1;
        ld = 1'b0; enable = 1'b0;
        total++; if (dir_status_o !== 1'b0) $display("FAIL b2b_status_clear got %b want 0", dir_status_o); else passed++;
        measure(1, lat, st);
        total++; if (lat !== 5 || st !== 1'b1) $display("FAIL b2b_walk got lat=%0d st=%b want lat=5 st=1", lat, st); else passed++;
    endtask

    task automatic test_random();
        int lat, elat, nrun, origin, step, k; logic st, est, fl; logic [1:0] pl;
        for (int it = 0; it < 60; it++) begin
            blank_shadow();
            for (int r = 1; r <= 8; r++)
                for (int c = 1; c <= 8; c++) begin
                    k = $urandom_range(0, 2);
                    shadow[r * 10 + c] = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
                end
            load_board();
            if ($urandom_range(0, 9) < 7) origin = $urandom_range(1, 8) * 10 + $urandom_range(1, 8);
            else                          origin = $urandom_range(0, 99);
            step = steps[$urandom_range(0, 7)];
            pl   = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            fl   = 1'($urandom_range(0, 1));
            model_walk(origin, step, pl, fl, elat, est, nrun);
            start_walk(origin, step, pl, fl, 1'b1);
            measure(1, lat, st);
            total++; if (lat !== elat) $display("FAIL rand_latency it=%0d o=%0d s=%0d got %0d want %0d", it, origin, step, lat, elat); else passed++;
            total++; if (st !== est) $display("FAIL rand_status it=%0d o=%0d s=%0d got %b want %b", it, origin, step, st, est); else passed++;
            k = (FLIP_ON && fl && est) ? nrun : 0;
            total++;
            if (wr_addr_q.size() != k) $display("FAIL rand_write_count it=%0d got %0d want %0d", it, wr_addr_q.size(), k);
            else begin
                passed++;
                for (int w = 0; w < k; w++) begin
                    total++;
                    if (wr_addr_q[w] != origin + (nrun - w) * step || wr_data_q[w] !== pl)
                        $display("FAIL rand_write it=%0d w=%0d got %0d/%b want %0d/%b", it, w,
                                 wr_addr_q[w], wr_data_q[w], origin + (nrun - w) * step, pl);
                    else passed++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_flip();
        test_blocked();
        test_range();
        test_max_run();
        test_reset_midwalk();
        test_enable_ignored();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
